// File: rtl/mux_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_if
//  Description : Control, data and handshake bundle for the mux_scan channel
//                selector.
//  Revision    : 1.0
// ============================================================================
interface mux_scan_if #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 1
);
   localparam int SW = (N_CH > 2) ? $clog2(N_CH) : 1;

   logic                  en;
   logic                  mode;
   logic [SW-1:0]         sel;
   logic [N_CH*WIDTH-1:0] din;
   logic                  out_ready;
   logic                  out_valid;
   logic [WIDTH-1:0]      dout;
   logic [SW-1:0]         ch_out;
   logic                  sel_err;

   modport master (
      output en, mode, sel, din, out_ready,
      input  out_valid, dout, ch_out, sel_err
   );

   modport slave (
      input  en, mode, sel, din, out_ready,
      output out_valid, dout, ch_out, sel_err
   );
endinterface
`default_nettype wire

// File: rtl/mux_scan.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan
//  Description : Registered N-channel sample selector with manual select and
//                dwell-based auto-scan, ready/valid output handshake.
//  Revision    : 1.0
// ============================================================================
module mux_scan #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 1,
   parameter int DWELL = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   mux_scan_if.slave    bus
);
   localparam int         SW         = (N_CH > 2) ? $clog2(N_CH) : 1;
   localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

   logic             mode_d;
   logic [SW-1:0]    scan_ch;
   logic [7:0]       dwell_cnt;

   logic             load;
   logic             rise;
   logic             sel_oob;
   logic [SW-1:0]    start_ch;
   logic [SW-1:0]    ptr;
   logic [SW-1:0]    cur;
   logic [SW-1:0]    scan_nxt;
   logic [7:0]       cnt;
   logic [7:0]       dwell_nxt;
   logic [WIDTH-1:0] sample;

   generate
      if ((N_CH & (N_CH - 1)) == 0) begin : g_pow2
         assign sel_oob = 1'b0;
      end else begin : g_oob
         assign sel_oob = ({1'b0, bus.sel} >= (SW + 1)'(N_CH));
      end
   endgenerate

   // On a mode rising edge the capture in that same cycle already uses the
   // reloaded pointer and counts as the first transfer of its dwell.
   always_comb begin
      load      = bus.en && (!bus.out_valid || bus.out_ready);
      rise      = bus.mode && !mode_d;
      start_ch  = sel_oob ? '0 : bus.sel;
      ptr       = rise ? start_ch : scan_ch;
      cnt       = rise ? 8'd0 : dwell_cnt;
      cur       = bus.mode ? ptr : bus.sel;
      scan_nxt  = ptr;
      dwell_nxt = cnt;
      if (load && bus.mode) begin
         if (cnt >= DWELL_LAST) begin
            dwell_nxt = 8'd0;
            scan_nxt  = (ptr == SW'(N_CH - 1)) ? '0 : ptr + SW'(1);
         end else begin
            dwell_nxt = cnt + 8'd1;
         end
      end
   end

   // Out-of-range indices match no channel, so the sample falls back to zero.
   always_comb begin
      sample = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (cur == SW'(k)) begin
            sample = bus.din[k*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_d        <= 1'b0;
         scan_ch       <= '0;
         dwell_cnt     <= 8'd0;
         bus.out_valid <= 1'b0;
         bus.dout      <= '0;
         bus.ch_out    <= '0;
         bus.sel_err   <= 1'b0;
      end else begin
         mode_d    <= bus.mode;
         scan_ch   <= scan_nxt;
         dwell_cnt <= dwell_nxt;
         if (load) begin
            bus.out_valid <= 1'b1;
            bus.dout      <= sample;
            bus.ch_out    <= cur;
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
         bus.sel_err <= load && !bus.mode && sel_oob;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_mux_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_scan
//  Description : Directed self-checking bench for mux_scan (4- and 5-channel).
//  Revision    : 1.0
// ============================================================================
module tb_mux_scan;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   localparam logic [31:0] BASE4 = {8'h44, 8'h33, 8'h22, 8'h11};
   localparam logic [39:0] BASE5 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};

   mux_scan_if #(.N_CH(4), .WIDTH(8)) bus4 ();
   mux_scan_if #(.N_CH(5), .WIDTH(8)) bus5 ();

   mux_scan #(.N_CH(4), .WIDTH(8), .DWELL(2)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4.slave)
   );

   mux_scan #(.N_CH(5), .WIDTH(8), .DWELL(1)) u_dut5 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus5.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check4(input string tag, input logic [1:0] ch, input logic [7:0] d);
      check({tag, " valid"}, 32'(bus4.out_valid), 32'd1);
      check({tag, " ch"},    32'(bus4.ch_out),    32'(ch));
      check({tag, " dout"},  32'(bus4.dout),      32'(d));
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus4.en = 1'b0; bus4.mode = 1'b0; bus4.sel = '0; bus4.din = BASE4; bus4.out_ready = 1'b1;
      bus5.en = 1'b0; bus5.mode = 1'b0; bus5.sel = '0; bus5.din = BASE5; bus5.out_ready = 1'b1;

      // Reset state
      #2;
      check("rst valid", 32'(bus4.out_valid), 32'd0);
      check("rst dout",  32'(bus4.dout),      32'd0);
      check("rst ch",    32'(bus4.ch_out),    32'd0);
      check("rst err5",  32'(bus5.sel_err),   32'd0);
      step();
      step();
      check("rst hold valid", 32'(bus4.out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Manual capture
      bus4.en = 1'b1; bus4.sel = 2'd2;
      step();
      check4("man", 2'd2, 8'h33);

      // Drain with en=0: valid drops, data kept
      bus4.en = 1'b0;
      step();
      check("drain valid", 32'(bus4.out_valid), 32'd0);
      check("drain dout",  32'(bus4.dout),      32'h33);

      // Scan with DWELL=2: 0,0,1,1,2,2,3,3,0
      bus4.mode = 1'b1; bus4.sel = 2'd0; bus4.en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         logic [1:0] ch;
         ch = 2'((i / 2) % 4);
         step();
         check4("scan", ch, 8'(8'h11 * (ch + 1)));
      end

      // Stall with changing din
      bus4.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus4.din = {4{8'(8'hA0 + i)}};
         step();
         check4("stall", 2'd0, 8'h11);
      end
      bus4.din = BASE4; bus4.out_ready = 1'b1;
      step(); check4("resume0", 2'd0, 8'h11);
      step(); check4("resume1", 2'd1, 8'h22);
      step(); check4("resume2", 2'd1, 8'h22);
      step(); check4("resume3", 2'd2, 8'h33);

      // Asynchronous reset mid-dwell
      rst_n = 1'b0;
      #1;
      check("arst valid", 32'(bus4.out_valid), 32'd0);
      check("arst dout",  32'(bus4.dout),      32'd0);
      check("arst ch",    32'(bus4.ch_out),    32'd0);
      #2;
      rst_n = 1'b1;
      step(); check4("rescan0", 2'd0, 8'h11);
      step(); check4("rescan1", 2'd0, 8'h11);
      step(); check4("rescan2", 2'd1, 8'h22);

      // Mode switch from manual sel=3, wrap to 0
      bus4.mode = 1'b0; bus4.sel = 2'd3;
      step(); check4("sw man", 2'd3, 8'h44);
      bus4.mode = 1'b1;
      step(); check4("sw s0", 2'd3, 8'h44);
      step(); check4("sw s1", 2'd3, 8'h44);
      step(); check4("sw s2", 2'd0, 8'h11);
      step(); check4("sw s3", 2'd0, 8'h11);
      step(); check4("sw s4", 2'd1, 8'h22);
      check("pow2 err", 32'(bus4.sel_err), 32'd0);
      bus4.en = 1'b0;

      // Out-of-range manual select on the 5-channel instance
      bus5.en = 1'b1; bus5.sel = 3'd6;
      step();
      check("oob valid", 32'(bus5.out_valid), 32'd1);
      check("oob dout",  32'(bus5.dout),      32'd0);
      check("oob ch",    32'(bus5.ch_out),    32'd6);
      check("oob err",   32'(bus5.sel_err),   32'd1);
      bus5.sel = 3'd4;
      step();
      check("ok5 dout", 32'(bus5.dout),    32'h55);
      check("ok5 ch",   32'(bus5.ch_out),  32'd4);
      check("ok5 err",  32'(bus5.sel_err), 32'd0);
      bus5.en = 1'b0;
      step();
      check("idle5 valid", 32'(bus5.out_valid), 32'd0);
      check("idle5 err",   32'(bus5.sel_err),   32'd0);

      // DWELL=1 scan, out-of-range sel clamps start to 0
      bus5.mode = 1'b1; bus5.sel = 3'd6; bus5.en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         logic [2:0] ch;
         ch = 3'(i % 5);
         step();
         check("d1 ch",   32'(bus5.ch_out),  32'(ch));
         check("d1 dout", 32'(bus5.dout),    32'(8'(8'h11 * (ch + 1))));
         check("d1 err",  32'(bus5.sel_err), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
